branch_control: RTL and testbench

BRANCH_CONTROL -- requirements
Module: branch_control

---
 rtl/branch_control_pkg.sv | 15 +
 rtl/sat_counter16.sv | 23 ++
 rtl/branch_control.sv | 116 +++++++++++
 tb/tb_branch_control.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_control_pkg.sv
// Shared processor defines for the branch redirect controller: FSM state
// encodings, default flush depth and event counter widths.
package branch_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } br_state_e;

  localparam int FLUSH_DEPTH_DEF = 2;
  localparam int CNT_W           = 16;
  localparam int DRAIN_W         = 3;

endpackage

// File: rtl/sat_counter16.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter16
  import branch_control_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/branch_control.sv
// Branch redirect controller: captures a taken target, drives the PC select
// for one cycle, then keeps fetch squashed for the remaining drain cycles.
module branch_control
  import branch_control_pkg::*;
#(
  parameter int FLUSH_DEPTH = FLUSH_DEPTH_DEF,
  parameter int ADDR_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              stall_in,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic              flush_if,
  output logic              flush_id,
  output logic              busy,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  taken_count,
  output logic [1:0]        dbg_state
);

  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(FLUSH_DEPTH - 1);

  br_state_e          r_state;
  br_state_e          w_state_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_drain_nxt;
  logic [ADDR_W-1:0]  r_pc_target;
  logic               r_misalign;
  logic               w_accept;
  logic               w_accept_taken;

  // Handshake: a branch is consumed on any edge where the controller is IDLE,
  // br_valid=1 and stall_in=0; there is no ready output, wrong-path branches
  // seen while busy are silently dropped.
  assign w_accept       = (r_state == ST_IDLE) && br_valid && !stall_in;
  assign w_accept_taken = w_accept && br_taken;

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_taken) w_state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        if (!stall_in) begin
          if (FLUSH_DEPTH == 1) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = DRAIN_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (!stall_in) begin
          if (r_drain_cnt == DRAIN_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_drain_nxt = '0;
          end else begin
            w_drain_nxt = r_drain_cnt - 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_drain_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= '0;
      r_pc_target <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (w_accept_taken) begin
        r_pc_target <= {br_target[ADDR_W-1:2], 2'b00};
        if (br_target[1:0] != 2'b00) r_misalign <= 1'b1;
      end
    end
  end

  sat_counter16 u_br_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_accept),
    .count (br_count)
  );

  sat_counter16 u_taken_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (w_accept_taken),
    .count (taken_count)
  );

  // Outputs decode state only, so reset clears them the instant it asserts.
  assign pc_sel       = (r_state == ST_REDIRECT);
  assign flush_id     = (r_state == ST_REDIRECT);
  assign flush_if     = (r_state != ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign pc_target    = r_pc_target;
  assign misalign_err = r_misalign;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_branch_control.sv
// Self-checking bench for branch_control: directed vector table, randomized
// run against a flush-budget model, reset abort and counter saturation.
module tb_branch_control;

  localparam int FD = 2;
  localparam int AW = 32;

  logic          clock;
  logic          reset;
  logic          br_valid;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          stall_in;
  logic          pc_sel;
  logic [AW-1:0] pc_target;
  logic          flush_if;
  logic          flush_id;
  logic          busy;
  logic          misalign_err;
  logic [15:0]   br_count;
  logic [15:0]   taken_count;
  logic [1:0]    dbg_state;

  int checks;
  int failures;

  branch_control #(.FLUSH_DEPTH(FD), .ADDR_W(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .stall_in     (stall_in),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .busy         (busy),
    .misalign_err (misalign_err),
    .br_count     (br_count),
    .taken_count  (taken_count),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic        t;
    logic [31:0] tgt;
    logic        s;
    logic        e_sel;
    logic        e_fif;
    logic        e_fid;
    logic        e_busy;
    logic [31:0] e_pct;
    int          e_br;
    int          e_tk;
    logic        e_mis;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic t, input logic [31:0] tgt, input logic s);
    br_valid  = v;
    br_taken  = t;
    br_target = tgt;
    stall_in  = s;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after rising.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Model: after a taken branch the controller owes FD unstalled flush
  // cycles; the first of them is the redirect cycle.
  int          m_rem;
  int          m_br;
  int          m_tk;
  logic [31:0] m_pct;
  logic        m_mis;

  task automatic model_reset();
    m_rem = 0; m_br = 0; m_tk = 0; m_pct = 32'h0; m_mis = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic t, input logic [31:0] tgt, input logic s);
    if (m_rem == 0) begin
      if (v && !s) begin
        if (m_br < 65535) m_br++;
        if (t) begin
          if (m_tk < 65535) m_tk++;
          m_pct = tgt & 32'hFFFF_FFFC;
          if (tgt[1:0] != 2'b00) m_mis = 1'b1;
          m_rem = FD;
        end
      end
    end else if (!s) begin
      m_rem--;
    end
  endtask

  task automatic model_cmp(input string tag);
    chk({tag, ".pc_sel"},   32'(pc_sel),   32'(m_rem == FD));
    chk({tag, ".flush_id"}, 32'(flush_id), 32'(m_rem == FD));
    chk({tag, ".flush_if"}, 32'(flush_if), 32'(m_rem > 0));
    chk({tag, ".busy"},     32'(busy),     32'(m_rem > 0));
    chk({tag, ".pc_target"}, pc_target, m_pct);
    chk({tag, ".misalign"}, 32'(misalign_err), 32'(m_mis));
    chk({tag, ".br_count"}, 32'(br_count), 32'(m_br));
    chk({tag, ".taken_count"}, 32'(taken_count), 32'(m_tk));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst.pc_sel",   32'(pc_sel),   32'h0);
    chk("rst.flush_if", 32'(flush_if), 32'h0);
    chk("rst.flush_id", 32'(flush_id), 32'h0);
    chk("rst.busy",     32'(busy),     32'h0);
    chk("rst.pc_target", pc_target,    32'h0);
    chk("rst.misalign", 32'(misalign_err), 32'h0);
    chk("rst.br_count", 32'(br_count), 32'h0);
    chk("rst.taken_count", 32'(taken_count), 32'h0);

    // directed table: expected outputs after the edge that consumes the row
    vq.push_back('{1'b1, 1'b1, 32'h0040_0040, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0040, 1, 1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0040, 1, 1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0040, 1, 1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0040, 2, 1, 1'b0});
    vq.push_back('{1'b1, 1'b1, 32'h0040_0043, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0040, 3, 2, 1'b1});
    vq.push_back('{1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0040, 3, 2, 1'b1});
    vq.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0040, 3, 2, 1'b1});
    vq.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0040, 3, 2, 1'b1});
    vq.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0040_0040, 3, 2, 1'b1});
    vq.push_back('{1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0040, 3, 2, 1'b1});
    vq.push_back('{1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0040, 3, 2, 1'b1});
    vq.push_back('{1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 4, 3, 1'b1});

    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].v, vq[i].t, vq[i].tgt, vq[i].s);
      cycle();
      chk($sformatf("vec%0d.pc_sel", i),   32'(pc_sel),   32'(vq[i].e_sel));
      chk($sformatf("vec%0d.flush_if", i), 32'(flush_if), 32'(vq[i].e_fif));
      chk($sformatf("vec%0d.flush_id", i), 32'(flush_id), 32'(vq[i].e_fid));
      chk($sformatf("vec%0d.busy", i),     32'(busy),     32'(vq[i].e_busy));
      chk($sformatf("vec%0d.pc_target", i), pc_target,    vq[i].e_pct);
      chk($sformatf("vec%0d.br_count", i), 32'(br_count), 32'(vq[i].e_br));
      chk($sformatf("vec%0d.taken_count", i), 32'(taken_count), 32'(vq[i].e_tk));
      chk($sformatf("vec%0d.misalign", i), 32'(misalign_err), 32'(vq[i].e_mis));
      @(negedge clock);
    end

    // randomized run against the flush-budget model
    do_reset();
    model_reset();
    for (int i = 0; i < 2000; i++) begin
      logic rv, rt, rs;
      logic [31:0] rtgt;
      rv   = 1'($urandom_range(0, 1));
      rt   = 1'($urandom_range(0, 1));
      rs   = ($urandom_range(0, 3) == 0);
      rtgt = $urandom;
      drive(rv, rt, rtgt, rs);
      model_step(rv, rt, rtgt, rs);
      cycle();
      model_cmp($sformatf("rnd%0d", i));
      @(negedge clock);
    end

    // reset asserted mid-REDIRECT aborts at once
    do_reset();
    @(negedge clock);
    drive(1'b1, 1'b1, 32'h0000_1000, 1'b0);
    cycle();
    chk("abort.pre_pc_sel", 32'(pc_sel), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort.pc_sel",   32'(pc_sel),   32'h0);
    chk("abort.flush_if", 32'(flush_if), 32'h0);
    chk("abort.flush_id", 32'(flush_id), 32'h0);
    chk("abort.busy",     32'(busy),     32'h0);
    chk("abort.pc_target", pc_target,    32'h0);
    chk("abort.br_count", 32'(br_count), 32'h0);
    // first edge after deassertion accepts a branch
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 1'b1, 32'h0000_2004, 1'b0);
    cycle();
    chk("first_edge.pc_sel",    32'(pc_sel),    32'h1);
    chk("first_edge.pc_target", pc_target,      32'h0000_2004);
    chk("first_edge.br_count",  32'(br_count),  32'h1);
    @(negedge clock);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    chk("first_edge.drain_fif", 32'(flush_if), 32'h1);
    @(negedge clock);
    cycle();
    chk("first_edge.idle_busy", 32'(busy), 32'h0);

    // counter saturation
    do_reset();
    @(negedge clock);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (70000) @(posedge clock);
    #1;
    chk("sat.br_count",    32'(br_count),    32'h0000_FFFF);
    chk("sat.taken_count", 32'(taken_count), 32'h0);
    chk("sat.busy",        32'(busy),        32'h0);
    @(negedge clock);
    drive(1'b1, 1'b1, 32'h0000_0010, 1'b0);
    cycle();
    chk("sat.hold_br",  32'(br_count),    32'h0000_FFFF);
    chk("sat.taken_1",  32'(taken_count), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
